// File: rtl/gray_rx_checker.sv
// Gray-code receive checker: decodes sampled Gray counts, verifies each sample
// advances by exactly one, locks after a run of good steps and flags breaks.
module gray_rx_checker #(
  parameter int unsigned CBITS    = 14,
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CBITS-1:0] gray_in,
  input  logic             err_clr,
  output logic [CBITS-1:0] bin_out,
  output logic             bin_valid,
  output logic             locked,
  output logic             wrap,
  output logic             step_err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {StUnlocked, StTrack, StLocked} state_e;

  localparam logic [3:0]       LockCntW = 4'(LOCK_CNT);
  localparam logic [CBITS-1:0] OneW     = {{(CBITS-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CBITS-1:0] prev_q, prev_d;
  logic [3:0]       run_q, run_d;
  logic [CBITS-1:0] bin_out_q, bin_out_d;
  logic             bin_valid_q, bin_valid_d;
  logic             locked_q, locked_d;
  logic             wrap_q, wrap_d;
  logic             step_err_q, step_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic [CBITS-1:0] bin;
  logic [CBITS-1:0] prev_inc;
  logic             is_good, is_hold, bad_evt;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < int'(CBITS); i++) begin
      bin[i] = ^(gray_in >> i);
    end
  end

  assign prev_inc = prev_q + OneW;
  assign is_good  = (bin == prev_inc);
  assign is_hold  = (bin == prev_q);

  // Next-state: step classification, lock FSM, pulses and error counter.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    run_d       = run_q;
    bin_out_d   = bin_out_q;
    bin_valid_d = 1'b0;
    wrap_d      = 1'b0;
    step_err_d  = 1'b0;
    bad_evt     = 1'b0;
    if (in_valid) begin
      bin_valid_d = 1'b1;
      bin_out_d   = bin;
      unique case (state_q)
        StUnlocked: begin
          // First sample only seeds the reference.
          prev_d  = bin;
          run_d   = 4'd0;
          state_d = StTrack;
        end
        StTrack: begin
          if (is_good) begin
            prev_d = bin;
            run_d  = run_q + 4'd1;
            if (run_q + 4'd1 == LockCntW) state_d = StLocked;
          end else if (!is_hold) begin
            prev_d = bin;
            run_d  = 4'd0;
          end
        end
        StLocked: begin
          if (is_good) begin
            prev_d = bin;
            wrap_d = (bin == '0);
          end else if (!is_hold) begin
            prev_d     = bin;
            run_d      = 4'd0;
            step_err_d = 1'b1;
            bad_evt    = 1'b1;
            state_d    = StTrack;
          end
        end
        default: state_d = StUnlocked;
      endcase
    end
    locked_d = (state_d == StLocked);

    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = bad_evt ? 8'd1 : 8'd0;
    end else if (bad_evt && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StUnlocked;
      prev_q      <= '0;
      run_q       <= 4'd0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      wrap_q      <= 1'b0;
      step_err_q  <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      bin_out_q   <= bin_out_d;
      bin_valid_q <= bin_valid_d;
      locked_q    <= locked_d;
      wrap_q      <= wrap_d;
      step_err_q  <= step_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bin_out   = bin_out_q;
  assign bin_valid = bin_valid_q;
  assign locked    = locked_q;
  assign wrap      = wrap_q;
  assign step_err  = step_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gray_rx_checker.sv
// Directed bench for gray_rx_checker with CBITS = 4, LOCK_CNT = 3.
module tb_gray_rx_checker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] gray_in;
  logic       err_clr;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       locked;
  logic       wrap;
  logic       step_err;
  logic [7:0] err_cnt;

  int tests = 0;
  int fails = 0;

  gray_rx_checker #(
    .CBITS   (4),
    .LOCK_CNT(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .gray_in  (gray_in),
    .err_clr  (err_clr),
    .bin_out  (bin_out),
    .bin_valid(bin_valid),
    .locked   (locked),
    .wrap     (wrap),
    .step_err (step_err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] gray(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one sample; return 1 time unit after the capturing edge.
  task automatic send(input logic [3:0] g);
    @(negedge clk);
    in_valid = 1'b1;
    gray_in  = g;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int cur;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    gray_in  = 4'd0;
    err_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bin_out", bin_out, 0);
    chk("rst_bin_valid", bin_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Lock-in
    send(4'b0000);
    chk("lk0_bin", bin_out, 0);
    chk("lk0_valid", bin_valid, 1);
    chk("lk0_locked", locked, 0);
    send(4'b0001);
    chk("lk1_bin", bin_out, 1);
    chk("lk1_locked", locked, 0);
    send(4'b0011);
    chk("lk2_bin", bin_out, 2);
    chk("lk2_locked", locked, 0);
    send(4'b0010);
    chk("lk3_bin", bin_out, 3);
    chk("lk3_locked", locked, 1);
    chk("lk3_step_err", step_err, 0);

    // Break and re-lock
    send(4'b0111);
    chk("brk_bin", bin_out, 5);
    chk("brk_step_err", step_err, 1);
    chk("brk_err_cnt", err_cnt, 1);
    chk("brk_locked", locked, 0);
    send(gray(6));
    chk("rl6_step_err", step_err, 0);
    chk("rl6_locked", locked, 0);
    send(gray(7));
    chk("rl7_locked", locked, 0);
    send(gray(8));
    chk("rl8_locked", locked, 1);

    // Wrap through zero
    for (int b = 9; b <= 13; b++) send(gray(b));
    send(4'b1001);
    chk("wr14_bin", bin_out, 14);
    chk("wr14_wrap", wrap, 0);
    send(4'b1000);
    chk("wr15_bin", bin_out, 15);
    chk("wr15_wrap", wrap, 0);
    send(4'b0000);
    chk("wr0_bin", bin_out, 0);
    chk("wr0_wrap", wrap, 1);
    chk("wr0_locked", locked, 1);
    chk("wr0_step_err", step_err, 0);
    send(gray(1));
    chk("wr1_wrap", wrap, 0);

    // Hold samples with gaps
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("gap_valid", bin_valid, 0);
      send(gray(1));
      chk("hold_valid", bin_valid, 1);
      chk("hold_bin", bin_out, 1);
      chk("hold_step_err", step_err, 0);
      chk("hold_locked", locked, 1);
    end
    send(gray(2));
    chk("after_hold_step_err", step_err, 0);
    chk("after_hold_locked", locked, 1);
    chk("after_hold_err_cnt", err_cnt, 1);

    // Saturation: each iteration one error (skip a count) then 3 good steps
    cur = 2;
    for (int k = 0; k < 256; k++) begin
      cur = cur + 2;
      send(gray(cur));
      if (k == 0) chk("sat_first_err_cnt", err_cnt, 2);
      for (int j = 0; j < 3; j++) begin
        cur = cur + 1;
        send(gray(cur));
      end
    end
    chk("sat_locked", locked, 1);
    chk("sat_err_cnt", err_cnt, 255);
    err_clr = 1'b1;
    cur = cur + 2;
    send(gray(cur));
    err_clr = 1'b0;
    chk("clr_err_step_err", step_err, 1);
    chk("clr_err_cnt", err_cnt, 1);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    chk("clr_only_err_cnt", err_cnt, 0);

    // Relock, then asynchronous reset mid-cycle
    for (int j = 0; j < 3; j++) begin
      cur = cur + 1;
      send(gray(cur));
    end
    chk("pre_rst_locked", locked, 1);
    idle();
    #1;
    rst = 1'b1;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_bin_out", bin_out, 0);
    chk("arst_bin_valid", bin_valid, 0);
    chk("arst_wrap", wrap, 0);
    chk("arst_step_err", step_err, 0);
    @(negedge clk);
    rst = 1'b0;
    send(gray(7));
    chk("seed_valid", bin_valid, 1);
    chk("seed_bin", bin_out, 7);
    chk("seed_locked", locked, 0);
    chk("seed_wrap", wrap, 0);
    chk("seed_step_err", step_err, 0);
    chk("seed_err_cnt", err_cnt, 0);
    send(gray(9));
    chk("track_bad_step_err", step_err, 0);
    chk("track_bad_locked", locked, 0);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
